seq_step_ctrl: RTL and testbench
================================

Name: seq_step_ctrl

Overview:
Run controller for the 8-state step-sequence generator. It decides when the generator advances, using a clear pulse, an advance-enable pulse, a programmable dwell time per state and a loop count. It accepts start/stop/single-step commands from the front panel logic and reports position, busy and done. It sits between the command logic and the generator's synchronous clear and enable inputs.

Parameters:
DWELL_W, 8, width of dwell value; each state is held for dwell+1 clock cycles.
LOOP_W, 4, width of loop count; 0 means free-run.
SEQ_LEN, 8, number of generator states per loop; the index is 3 bits.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  level-sampled; begin from IDLE, or resume from PAUSE
stop  in  1  level-sampled; pause from RUN, or abort from PAUSE
step_req  in  1  single-step request, honoured only in PAUSE
dwell  in  DWELL_W  cycles per state minus 1; latched in CLEAR
loops  in  LOOP_W  number of full loops to run, 0 = endless; latched in CLEAR
seq_clr  out  1  synchronous clear to the generator, 1-cycle pulse
seq_en  out  1  advance enable to the generator, 1-cycle pulse per step
pos  out  3  mirror of the generator index, 0..SEQ_LEN-1
loop_cnt  out  LOOP_W  number of completed loops
busy  out  1  high in CLEAR, RUN, PAUSE
done  out  1  1-cycle pulse when the programmed loop count completes

Behaviour:
- Reset (rst=0, async), all outputs: state=IDLE, seq_clr=0, seq_en=0, pos=0, loop_cnt=0, busy=0, done=0; dwell counter=0; step flag=0.
- All outputs are driven from registers or from state decode; there is no combinational path from input to output.
- IDLE: start=1 -> CLEAR. step_req and stop are ignored.
- CLEAR (1 cycle):
  - seq_clr=1.
  - Latch dwell and loops.
  - Load cnt=dwell, pos=0, loop_cnt=0.
  - Go to RUN.
- RUN:
  - If cnt!=0: cnt decrements.
  - If cnt==0: seq_en=1 this cycle and cnt reloads the latched dwell.
  - On the edge that ends a seq_en cycle, pos increments; 7 wraps to 0.
  - On a wrap, loop_cnt increments; it saturates at all-ones when loops=0.
  - If loops!=0 and the wrap makes loop_cnt==loops: next state FINISH.
- Timing:
  - start sampled at edge k -> CLEAR during cycle k+1 -> RUN from k+2.
  - First seq_en in cycle k+2+dwell.
  - Following seq_en pulses every dwell+1 cycles.
  - dwell=0 gives seq_en on every RUN cycle.
- stop=1 in RUN -> PAUSE at the next edge.
  - cnt and pos freeze, and no seq_en is issued from that edge onward.
  - If cnt==0 in the stop cycle, that step still completes, because seq_en is already asserted.
- PAUSE:
  - stop=1 -> IDLE (abort). pos and loop_cnt hold, busy=0, done=0.
  - Otherwise start=1 -> RUN; cnt resumes from its frozen value.
  - Otherwise step_req=1 -> step flag set; next cycle seq_en=1 with the same pos/loop update as RUN; cnt is untouched.
  - step_req held high gives one step every 2 cycles (flag set, pulse, flag clear).
  - A step that completes the final loop -> FINISH.
- FINISH (1 cycle): done=1, busy=0, then IDLE. pos=0 and loop_cnt=loops remain visible.
- Simultaneous commands: stop beats start; start beats step_req.
- Changes to dwell or loops outside CLEAR have no effect until the next start from IDLE.
- Reset mid-operation returns to IDLE immediately. Generator reset is handled by the shared rst, so seq_clr is not asserted by reset.

Decomposition:
- Shared package seq_pkg:
  - State encoding constants IDLE, CLEAR, RUN, PAUSE, FINISH (3-bit).
  - SEQ_LEN.
  - Index width constant (3).
- One natural sub-module: seq_dwell_cnt, a loadable down-counter with reload, freeze and zero flag.
- FSM and position/loop tracking stay in the top module.

Test Plan:
- Reset during RUN (pos=5): rst low for 1 cycle -> all outputs 0 asynchronously; after release, IDLE with busy=0.
- dwell=0, loops=1, start pulse at edge k -> seq_clr in k+1; seq_en in k+2..k+9 (8 pulses); pos 1..7,0; FINISH at k+10 with done=1, loop_cnt=1; then IDLE.
- dwell=3, loops=0, start -> seq_en every 4 cycles (first at k+5); after 16 pulses loop_cnt=2 and done never asserts.
- dwell=2, run to pos=3, stop -> no seq_en while paused; start -> next seq_en arrives after the remaining frozen count and pos=4.
- PAUSE at pos=6, loops=1, step_req held 4 cycles -> 2 seq_en pulses 2 cycles apart; pos goes 7 then 0; done pulse follows the second step; FINISH -> IDLE.
- start and stop both high in RUN -> PAUSE; both high in PAUSE -> IDLE with busy=0 and done=0; step_req in IDLE -> no seq_en.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the step-sequence run controller.
// Index width is fixed by the 8-state generator.
package seq_pkg;

  localparam int SEQ_LEN = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/seq_dwell_cnt.sv
// Loadable dwell down-counter: reloads on zero while running,
// holds its value while not running.
module seq_dwell_cnt #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               run,
  input  logic [DWELL_W-1:0] reload_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (run) begin
      if (cnt_q == '0) cnt_q <= reload_val;
      else             cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_step_ctrl.sv
// Run controller for the 8-state step-sequence generator:
// clear/advance pulses, dwell timing, loop counting, pause/step.
module seq_step_ctrl
  import seq_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int LOOP_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               step_req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LOOP_W-1:0]  loops,
  output logic               seq_clr,
  output logic               seq_en,
  output logic [IDX_W-1:0]   pos,
  output logic [LOOP_W-1:0]  loop_cnt,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q;
  logic [LOOP_W-1:0]  loops_q;
  logic [LOOP_W-1:0]  loop_next;
  logic               step_q;
  logic               cnt_zero;
  logic               wrap;
  logic               last_loop;

  seq_dwell_cnt #(.DWELL_W(DWELL_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (state_q == CLEAR),
    .load_val   (dwell),
    .run        (state_q == RUN),
    .reload_val (dwell_q),
    .zero       (cnt_zero)
  );

  assign seq_en = (state_q == RUN && cnt_zero)
               || (state_q == PAUSE && step_q);
  assign seq_clr = (state_q == CLEAR);
  assign done    = (state_q == FINISH);
  assign busy    = (state_q == CLEAR)
                || (state_q == RUN)
                || (state_q == PAUSE);

  assign wrap      = seq_en && (pos == LAST);
  assign loop_next = (&loop_cnt) ? loop_cnt
                                 : loop_cnt + LOOP_W'(1);
  assign last_loop = wrap && (loops_q != '0)
                  && (loop_next == loops_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR:  state_d = RUN;
      RUN: begin
        if (last_loop) state_d = FINISH;
        else if (stop) state_d = PAUSE;
      end
      PAUSE: begin
        if (last_loop)  state_d = FINISH;
        else if (stop)  state_d = IDLE;
        else if (start) state_d = RUN;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Flag self-clears after its pulse, so a held request steps every 2 cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= 1'b0;
    end else if (state_q != PAUSE || step_q) begin
      step_q <= 1'b0;
    end else if (step_req && !stop && !start) begin
      step_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_q <= '0;
      loops_q <= '0;
    end else if (state_q == CLEAR) begin
      dwell_q <= dwell;
      loops_q <= loops;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos      <= '0;
      loop_cnt <= '0;
    end else if (state_q == CLEAR) begin
      pos      <= '0;
      loop_cnt <= '0;
    end else if (seq_en) begin
      pos <= wrap ? '0 : pos + IDX_W'(1);
      if (wrap) loop_cnt <= loop_next;
    end
  end

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Directed self-checking bench for seq_step_ctrl.
module tb_seq_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step_req = 1'b0;
  logic [7:0] dwell = '0;
  logic [3:0] loops = '0;
  logic       seq_clr;
  logic       seq_en;
  logic [2:0] pos;
  logic [3:0] loop_cnt;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_step_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .step_req (step_req),
    .dwell    (dwell),
    .loops    (loops),
    .seq_clr  (seq_clr),
    .seq_en   (seq_en),
    .pos      (pos),
    .loop_cnt (loop_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE; returns positioned in the CLEAR cycle.
  task automatic launch(input logic [7:0] d, input logic [3:0] l);
    dwell = d;
    loops = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic abort_to_idle();
    stop = 1'b1;
    tick();
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({seq_clr, seq_en, pos, loop_cnt, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_init: got clr=%b en=%b pos=%0d lc=%0d busy=%b done=%b want all 0",
               seq_clr, seq_en, pos, loop_cnt, busy, done);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || seq_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b en=%b want 0 0", busy, seq_en);
    end
  endtask

  task automatic test_reset_mid();
    launch(8'd0, 4'd0);
    tick();
    repeat (5) tick();
    checks++;
    if (pos !== 3'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: pos=%0d busy=%b want 5 1", pos, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({seq_clr, seq_en, pos, loop_cnt, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_async: clr=%b en=%b pos=%0d lc=%0d busy=%b done=%b want all 0",
               seq_clr, seq_en, pos, loop_cnt, busy, done);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || seq_en !== 1'b0 || seq_clr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: busy=%b en=%b clr=%b want 0 0 0", busy, seq_en, seq_clr);
    end
  endtask

  task automatic test_single_loop();
    launch(8'd0, 4'd1);
    checks++;
    if (seq_clr !== 1'b1 || busy !== 1'b1 || seq_en !== 1'b0) begin
      errors++;
      $display("FAIL sl_clear: clr=%b busy=%b en=%b want 1 1 0", seq_clr, busy, seq_en);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (seq_en !== 1'b1 || pos !== 3'(i) || seq_clr !== 1'b0) begin
        errors++;
        $display("FAIL sl_run[%0d]: en=%b pos=%0d clr=%b want 1 %0d 0", i, seq_en, pos, seq_clr, i);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || loop_cnt !== 4'd1 || pos !== 3'd0 || seq_en !== 1'b0) begin
      errors++;
      $display("FAIL sl_finish: done=%b busy=%b lc=%0d pos=%0d en=%b want 1 0 1 0 0",
               done, busy, loop_cnt, pos, seq_en);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || loop_cnt !== 4'd1 || pos !== 3'd0) begin
      errors++;
      $display("FAIL sl_idle: done=%b busy=%b lc=%0d pos=%0d want 0 0 1 0", done, busy, loop_cnt, pos);
    end
  endtask

  task automatic test_free_run();
    int pulses;
    int bad;
    pulses = 0;
    bad = 0;
    launch(8'd3, 4'd0);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (seq_en !== ((i % 4) == 3)) bad++;
      if (done !== 1'b0) bad++;
      if (seq_en === 1'b1) pulses++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fr_period: %0d bad cycles want 0", bad);
    end
    checks++;
    if (pulses != 16) begin
      errors++;
      $display("FAIL fr_pulses: got %0d want 16", pulses);
    end
    tick();
    checks++;
    if (loop_cnt !== 4'd2 || pos !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL fr_end: lc=%0d pos=%0d busy=%b done=%b want 2 0 1 0", loop_cnt, pos, busy, done);
    end
    abort_to_idle();
  endtask

  task automatic test_pause_resume();
    int bad;
    bad = 0;
    launch(8'd2, 4'd0);
    repeat (9) tick();
    checks++;
    if (seq_en !== 1'b1 || pos !== 3'd2) begin
      errors++;
      $display("FAIL pr_pre: en=%b pos=%0d want 1 2", seq_en, pos);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (pos !== 3'd3 || busy !== 1'b1 || seq_en !== 1'b0) begin
      errors++;
      $display("FAIL pr_paused: pos=%0d busy=%b en=%b want 3 1 0", pos, busy, seq_en);
    end
    repeat (4) begin
      tick();
      if (seq_en !== 1'b0 || pos !== 3'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pr_hold: %0d bad cycles want 0", bad);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (seq_en !== 1'b0) begin
      errors++;
      $display("FAIL pr_resume0: en=%b want 0", seq_en);
    end
    tick();
    checks++;
    if (seq_en !== 1'b0) begin
      errors++;
      $display("FAIL pr_resume1: en=%b want 0", seq_en);
    end
    tick();
    checks++;
    if (seq_en !== 1'b1 || pos !== 3'd3) begin
      errors++;
      $display("FAIL pr_resume2: en=%b pos=%0d want 1 3", seq_en, pos);
    end
    tick();
    checks++;
    if (pos !== 3'd4 || seq_en !== 1'b0) begin
      errors++;
      $display("FAIL pr_after: pos=%0d en=%b want 4 0", pos, seq_en);
    end
    abort_to_idle();
  endtask

  task automatic test_step();
    logic       exp_en [4];
    logic [2:0] exp_pos [4];
    exp_en  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_pos = '{3'd6, 3'd6, 3'd7, 3'd7};
    launch(8'd0, 4'd1);
    repeat (6) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (pos !== 3'd6 || busy !== 1'b1 || seq_en !== 1'b0) begin
      errors++;
      $display("FAIL st_paused: pos=%0d busy=%b en=%b want 6 1 0", pos, busy, seq_en);
    end
    step_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (seq_en !== exp_en[i] || pos !== exp_pos[i]) begin
        errors++;
        $display("FAIL st_cyc[%0d]: en=%b pos=%0d want %b %0d", i, seq_en, pos, exp_en[i], exp_pos[i]);
      end
    end
    tick();
    step_req = 1'b0;
    checks++;
    if (done !== 1'b1 || pos !== 3'd0 || loop_cnt !== 4'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL st_finish: done=%b pos=%0d lc=%0d busy=%b want 1 0 1 0", done, pos, loop_cnt, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || seq_en !== 1'b0) begin
      errors++;
      $display("FAIL st_idle: done=%b busy=%b en=%b want 0 0 0", done, busy, seq_en);
    end
  endtask

  task automatic test_simultaneous();
    launch(8'd5, 4'd0);
    repeat (3) tick();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || seq_en !== 1'b0 || seq_clr !== 1'b0) begin
      errors++;
      $display("FAIL sim_pause: busy=%b en=%b clr=%b want 1 0 0", busy, seq_en, seq_clr);
    end
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL sim_abort: busy=%b done=%b want 0 0", busy, done);
    end
    step_req = 1'b1;
    tick();
    checks++;
    if (seq_en !== 1'b0 || busy !== 1'b0 || seq_clr !== 1'b0) begin
      errors++;
      $display("FAIL sim_idle_step0: en=%b busy=%b clr=%b want 0 0 0", seq_en, busy, seq_clr);
    end
    tick();
    step_req = 1'b0;
    checks++;
    if (seq_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sim_idle_step1: en=%b busy=%b want 0 0", seq_en, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_loop();
    test_free_run();
    test_pause_resume();
    test_step();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
